// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider and pulse-burst generator.
// Each channel free-runs a 50% divided clock or emits a counted burst of full periods.
module multi_clk_divider #(
  parameter int NUM_CH       = 4,
  parameter int COUNTER_BITS = 32,
  parameter int PULSE_BITS   = 32,
  localparam int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       out_enable,
  input  logic                    cfg_write,
  input  logic [CH_BITS-1:0]      cfg_channel,
  input  logic                    cfg_option,
  input  logic [COUNTER_BITS-1:0] cfg_divider,
  input  logic [PULSE_BITS-1:0]   cfg_pulse,
  input  logic                    sync_start,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [COUNTER_BITS-1:0] div_reg;
      logic [COUNTER_BITS-1:0] cnt_reg;
      logic [PULSE_BITS-1:0]   remaining_reg;
      logic                    option_reg;
      logic                    phase_reg;
      logic                    busy_reg;
      logic                    done_reg;

      logic sel;
      logic running;
      logic wrap;
      logic falling;
      logic last_fall;

      // Out-of-range channel numbers never match any gi, so such writes are dropped.
      assign sel       = cfg_write && (cfg_channel == CH_BITS'(gi));
      assign running   = out_enable[gi] && (option_reg || busy_reg);
      assign wrap      = (cnt_reg == div_reg);
      assign falling   = wrap && phase_reg && !option_reg;
      assign last_fall = falling && (remaining_reg == PULSE_BITS'(1));

      always_ff @(posedge clk) begin
        if (reset) begin
          div_reg       <= '0;
          option_reg    <= 1'b1;
          cnt_reg       <= '0;
          phase_reg     <= 1'b0;
          remaining_reg <= '0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end else if (sel) begin
          // A write replaces whatever was running, including a burst completing this edge.
          div_reg       <= cfg_divider;
          option_reg    <= cfg_option;
          cnt_reg       <= '0;
          phase_reg     <= 1'b0;
          remaining_reg <= cfg_option ? '0 : cfg_pulse;
          busy_reg      <= !cfg_option && (cfg_pulse != '0);
          done_reg      <= !cfg_option && (cfg_pulse == '0);
        end else begin
          done_reg <= 1'b0;
          if (sync_start) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
          end else if (running) begin
            if (wrap) begin
              cnt_reg   <= '0;
              phase_reg <= !phase_reg;
              if (falling) begin
                remaining_reg <= remaining_reg - PULSE_BITS'(1);
              end
              if (last_fall) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + COUNTER_BITS'(1);
            end
          end
        end
      end

      assign clk_o[gi] = phase_reg & out_enable[gi];
      assign busy[gi]  = busy_reg;
      assign done[gi]  = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_clk_divider.sv
// Bench for multi_clk_divider: directed scenarios plus random traffic against a
// period-position reference model (position within a full output period, periods left).
module tb_multi_clk_divider;
  localparam int NUM_CH = 5;
  localparam int CB     = 32;
  localparam int PB     = 32;
  localparam int CHB    = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NUM_CH-1:0] out_enable;
  logic            cfg_write;
  logic [CHB-1:0]  cfg_channel;
  logic            cfg_option;
  logic [CB-1:0]   cfg_divider;
  logic [PB-1:0]   cfg_pulse;
  logic            sync_start;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;

  always #5 clk = ~clk;

  multi_clk_divider #(
    .NUM_CH(NUM_CH), .COUNTER_BITS(CB), .PULSE_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .out_enable(out_enable),
    .cfg_write(cfg_write), .cfg_channel(cfg_channel), .cfg_option(cfg_option),
    .cfg_divider(cfg_divider), .cfg_pulse(cfg_pulse), .sync_start(sync_start),
    .clk_o(clk_o), .busy(busy), .done(done)
  );

  // Reference model: pos = clk cycles elapsed in the current full output period.
  longint unsigned m_div  [NUM_CH];
  bit              m_free [NUM_CH];
  longint unsigned m_pos  [NUM_CH];
  longint unsigned m_left [NUM_CH];
  bit              m_busy [NUM_CH];
  bit              m_done [NUM_CH];

  int n_pass  = 0;
  int n_total = 0;

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        m_div[c] = 0; m_free[c] = 1'b1; m_pos[c] = 0;
        m_left[c] = 0; m_busy[c] = 1'b0; m_done[c] = 1'b0;
      end else if (cfg_write && int'(cfg_channel) == c) begin
        m_div[c]  = longint'(cfg_divider);
        m_free[c] = cfg_option;
        m_pos[c]  = 0;
        m_left[c] = cfg_option ? 0 : longint'(cfg_pulse);
        m_busy[c] = !cfg_option && cfg_pulse != 0;
        m_done[c] = !cfg_option && cfg_pulse == 0;
      end else begin
        m_done[c] = 1'b0;
        if (sync_start) begin
          m_pos[c] = 0;
        end else if (out_enable[c] && (m_free[c] || m_busy[c])) begin
          m_pos[c]++;
          if (m_pos[c] == 2 * (m_div[c] + 1)) begin
            m_pos[c] = 0;
            if (!m_free[c]) begin
              m_left[c]--;
              if (m_left[c] == 0) begin
                m_busy[c] = 1'b0;
                m_done[c] = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check_outputs(string tag);
    logic [NUM_CH-1:0] ec, eb, ed;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c] = out_enable[c] && (m_pos[c] >= m_div[c] + 1);
      eb[c] = m_busy[c];
      ed[c] = m_done[c];
    end
    n_total++;
    assert (clk_o === ec) n_pass++;
    else $error("FAIL %s clk_o observed=%b expected=%b", tag, clk_o, ec);
    n_total++;
    assert (busy === eb) n_pass++;
    else $error("FAIL %s busy observed=%b expected=%b", tag, busy, eb);
    n_total++;
    assert (done === ed) n_pass++;
    else $error("FAIL %s done observed=%b expected=%b", tag, done, ed);
  endtask

  task automatic check_int(string tag, longint observed, longint expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    cfg_write  = 1'b0;
    sync_start = 1'b0;
  endtask

  task automatic write_cfg(int ch, bit opt, logic [CB-1:0] div, logic [PB-1:0] pls);
    cfg_write   = 1'b1;
    cfg_channel = CHB'(ch);
    cfg_option  = opt;
    cfg_divider = div;
    cfg_pulse   = pls;
  endtask

  initial begin
    int rises, done_cnt, done_idx, rise2, rise3;
    logic prev;

    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = 0; m_free[c] = 1'b1; m_pos[c] = 0;
      m_left[c] = 0; m_busy[c] = 1'b0; m_done[c] = 1'b0;
    end
    reset = 1'b1; out_enable = '1; cfg_write = 1'b0; cfg_channel = '0;
    cfg_option = 1'b0; cfg_divider = '0; cfg_pulse = '0; sync_start = 1'b0;

    // 1: reset state, then clk/2 on every channel
    repeat (3) tick("reset");
    check_int("reset_clk_o", longint'(clk_o), 0);
    reset = 1'b0;
    repeat (6) tick("t1_div2");

    // 2: ch1 free-run divider 3
    write_cfg(1, 1'b1, 32'd3, 32'd0);
    repeat (20) tick("t2_ch1_div3");

    // 3: ch0 burst of 8 periods, divider 1
    write_cfg(0, 1'b0, 32'd1, 32'd8);
    rises = 0; done_cnt = 0; done_idx = -1; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick("t3_burst");
      if (clk_o[0] && !prev) rises++;
      if (done[0]) begin done_cnt++; done_idx = i; end
      prev = clk_o[0];
    end
    check_int("t3_rises", rises, 8);
    check_int("t3_done_cnt", done_cnt, 1);
    check_int("t3_done_idx", done_idx, 32);

    // 4: same burst, gated for 10 cycles while phase is low
    write_cfg(0, 1'b0, 32'd1, 32'd8);
    rises = 0; done_cnt = 0; done_idx = -1; prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick("t4_gated");
      if (clk_o[0] && !prev) rises++;
      if (done[0]) begin done_cnt++; done_idx = i; end
      prev = clk_o[0];
      if (i == 4)  out_enable[0] = 1'b0;
      if (i == 14) out_enable[0] = 1'b1;
    end
    check_int("t4_rises", rises, 8);
    check_int("t4_done_cnt", done_cnt, 1);
    check_int("t4_done_idx", done_idx, 42);

    // 5: sync_start alignment of ch2 (div 2) and ch3 (div 0)
    write_cfg(2, 1'b1, 32'd2, 32'd0);
    tick("t5_cfg2");
    write_cfg(3, 1'b1, 32'd0, 32'd0);
    repeat (4) tick("t5_cfg3");
    sync_start = 1'b1;
    tick("t5_sync");
    check_int("t5_sync_low", longint'(clk_o[3:2]), 0);
    rise2 = -1; rise3 = -1;
    for (int i = 1; i <= 6; i++) begin
      tick("t5_after");
      if (clk_o[2] && rise2 < 0) rise2 = i;
      if (clk_o[3] && rise3 < 0) rise3 = i;
    end
    check_int("t5_rise_ch2", rise2, 3);
    check_int("t5_rise_ch3", rise3, 1);
    // write and sync on the same edge
    write_cfg(1, 1'b1, 32'd1, 32'd0);
    sync_start = 1'b1;
    repeat (8) tick("t5_write_sync");

    // 6: zero-length burst, out-of-range write, reset mid-burst
    write_cfg(0, 1'b0, 32'd2, 32'd0);
    tick("t6_n0");
    check_int("t6_n0_done", longint'(done[0]), 1);
    check_int("t6_n0_busy", longint'(busy[0]), 0);
    repeat (3) tick("t6_n0_after");
    write_cfg(NUM_CH, 1'b0, 32'd7, 32'd3);
    repeat (6) tick("t6_oor");
    write_cfg(4, 1'b0, 32'd0, 32'd1);
    tick("t6_ch4");
    tick("t6_ch4");
    // write lands on the completing edge: no done
    write_cfg(4, 1'b1, 32'd1, 32'd0);
    tick("t6_complete_write");
    check_int("t6_cw_done", longint'(done[4]), 0);
    write_cfg(1, 1'b0, 32'd2, 32'd5);
    repeat (5) tick("t6_burst");
    reset = 1'b1;
    tick("t6_reset");
    check_int("t6_reset_busy", longint'(busy), 0);
    check_int("t6_reset_done", longint'(done), 0);
    reset = 1'b0;
    repeat (6) tick("t6_resume");

    // maximum divider: output stays low for the short window observed
    write_cfg(2, 1'b1, 32'hFFFF_FFFF, 32'd0);
    repeat (5) tick("max_div");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        write_cfg(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 4)), 32'($urandom_range(0, 5)));
      if ($urandom_range(0, 19) == 0) sync_start = 1'b1;
      if ($urandom_range(0, 9) == 0) out_enable = NUM_CH'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
